// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid check controller and its stall watchdog.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ID  = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_RD_TS  = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_DONE   = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  function automatic logic is_read_state(input logic [2:0] s);
    return (s == ST_RD_ID) || (s == ST_RD_TS);
  endfunction

endpackage

// File: rtl/sysid_stall_wdog.sv
// Stall watchdog: down-counter reloaded on clear, expires on the TIMEOUT_CYC-th
// consecutive counted cycle. Used only when SYSID_CHECK_CTRL_TIMEOUT_EN is defined.
module sysid_stall_wdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic count,
  input  logic clear,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] remain;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      remain <= LOAD;
    end else if (count && (remain != '0)) begin
      remain <= remain - W'(1);
    end
  end

  assign expire = count && (remain == '0);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them to the
// expected build values. Optional stall watchdog: SYSID_CHECK_CTRL_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start (or the automatic check after reset)
// RD_ID  | read strobe to address 0, held through waitrequest
// LAT_ID | one-cycle read latency slot, captures the ID word
// RD_TS  | read strobe to address 1, held through waitrequest
// LAT_TS | one-cycle read latency slot, captures the timestamp word
// DONE   | result published one edge after entry; start restarts
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXP_ID       = 32'h524E_FFAE,
  parameter logic [31:0] EXP_TS       = 32'h4C34_5B1A,
  parameter int          READ_LATENCY = 0,
  parameter int          AUTO_START   = 1,
  parameter int          TIMEOUT_CYC  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        timeout
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] RD_ID  = ST_RD_ID;
  localparam logic [2:0] LAT_ID = ST_LAT_ID;
  localparam logic [2:0] RD_TS  = ST_RD_TS;
  localparam logic [2:0] LAT_TS = ST_LAT_TS;
  localparam logic [2:0] DONE   = ST_DONE;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       auto_pend;
  logic       rd_state;
  logic       rd_accept;
  logic       start_check;
  logic       wdog_expire;

  assign rd_state    = is_read_state(state);
  assign rd_accept   = rd_state && !avm_waitrequest;
  assign start_check = ((state == IDLE) && (start || auto_pend)) || ((state == DONE) && start);

`ifdef SYSID_CHECK_CTRL_TIMEOUT_EN
  logic wdog_count;
  assign wdog_count = rd_state && avm_waitrequest;

  sysid_stall_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .count  (wdog_count),
    .clear  (!wdog_count),
    .expire (wdog_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign wdog_expire        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_check) state_nxt = RD_ID;
      RD_ID: begin
        if (wdog_expire)    state_nxt = DONE;
        else if (rd_accept) state_nxt = (READ_LATENCY == 0) ? RD_TS : LAT_ID;
      end
      LAT_ID:  state_nxt = RD_TS;
      RD_TS: begin
        if (wdog_expire)    state_nxt = DONE;
        else if (rd_accept) state_nxt = (READ_LATENCY == 0) ? DONE : LAT_TS;
      end
      LAT_TS:  state_nxt = DONE;
      DONE:    if (start) state_nxt = RD_ID;
      default: state_nxt = IDLE;
    endcase
  end

  assign avm_read    = rd_state;
  assign avm_address = (state == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy        = rd_state || (state == LAT_ID) || (state == LAT_TS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      auto_pend <= (AUTO_START != 0);
      done      <= 1'b0;
      id_match  <= 1'b0;
      ts_match  <= 1'b0;
      timeout   <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      state <= state_nxt;
      if (start_check) auto_pend <= 1'b0;

      if (((state == RD_ID) && rd_accept && (READ_LATENCY == 0)) || (state == LAT_ID))
        id_value <= avm_readdata;
      if (((state == RD_TS) && rd_accept && (READ_LATENCY == 0)) || (state == LAT_TS))
        ts_value <= avm_readdata;

      // Matches are evaluated from the captured words, so they land with done.
      if (start_check) begin
        done     <= 1'b0;
        id_match <= 1'b0;
        ts_match <= 1'b0;
        timeout  <= 1'b0;
      end else if (rd_state && wdog_expire) begin
        timeout <= 1'b1;
      end else if ((state == DONE) && !done) begin
        done     <= 1'b1;
        id_match <= !timeout && (id_value == EXP_ID);
        ts_match <= !timeout && (ts_value == EXP_TS);
      end
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench: a zero-latency auto-start instance and a one-cycle-latency
// manual-start instance, each driven by a small sysid slave model.
module tb_sysid_check_ctrl;

  localparam logic [31:0] ID_W = 32'h524E_FFAE;
  localparam logic [31:0] TS_W = 32'h4C34_5B1A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // instance A: READ_LATENCY=0, AUTO_START=1
  logic        reset_a, start_a, ra_addr, ra_read, ra_wait, ra_busy, ra_done;
  logic        ra_idm, ra_tsm, ra_to;
  logic [31:0] ra_rdata, ra_idv, ra_tsv, slv_a_id, slv_a_ts;

  // instance B: READ_LATENCY=1, AUTO_START=0
  logic        reset_b, start_b, rb_addr, rb_read, rb_wait, rb_busy, rb_done;
  logic        rb_idm, rb_tsm, rb_to;
  logic [31:0] rb_rdata, rb_idv, rb_tsv;

  assign ra_rdata = ra_addr ? slv_a_ts : slv_a_id;

  always @(posedge clk) begin
    if (rb_read && !rb_wait) rb_rdata <= rb_addr ? TS_W : ID_W;
    else                     rb_rdata <= 32'hDEAD_BEEF;
  end

  sysid_check_ctrl #(
    .READ_LATENCY (0),
    .AUTO_START   (1),
    .TIMEOUT_CYC  (8)
  ) dut_a (
    .clock (clk), .reset (reset_a), .start (start_a),
    .avm_address (ra_addr), .avm_read (ra_read), .avm_readdata (ra_rdata),
    .avm_waitrequest (ra_wait), .busy (ra_busy), .done (ra_done),
    .id_match (ra_idm), .ts_match (ra_tsm), .id_value (ra_idv), .ts_value (ra_tsv),
    .timeout (ra_to)
  );

  sysid_check_ctrl #(
    .READ_LATENCY (1),
    .AUTO_START   (0),
    .TIMEOUT_CYC  (8)
  ) dut_b (
    .clock (clk), .reset (reset_b), .start (start_b),
    .avm_address (rb_addr), .avm_read (rb_read), .avm_readdata (rb_rdata),
    .avm_waitrequest (rb_wait), .busy (rb_busy), .done (rb_done),
    .id_match (rb_idm), .ts_match (rb_tsm), .id_value (rb_idv), .ts_value (rb_tsv),
    .timeout (rb_to)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ra_wait = 1'b0; rb_wait = 1'b0; slv_a_id = ID_W; slv_a_ts = TS_W;

    // reset state
    tick(2);
    check("rst_read", ra_read, 0);   check("rst_addr", ra_addr, 0);
    check("rst_busy", ra_busy, 0);   check("rst_done", ra_done, 0);
    check("rst_idv", ra_idv, 0);     check("rst_tsv", ra_tsv, 0);
    check("rst_match", {ra_idm, ra_tsm, ra_to}, 0);
    reset_a = 1'b0; reset_b = 1'b0;

    // automatic check after reset, zero wait
    tick();
    check("auto_rd_id", {ra_busy, ra_read, ra_addr}, 3'b110);
    check("auto_done_lo", ra_done, 0);
    tick();
    check("auto_rd_ts", {ra_busy, ra_read, ra_addr}, 3'b111);
    check("auto_idv", ra_idv, ID_W);
    tick();
    check("auto_done_st", {ra_busy, ra_read, ra_done}, 3'b000);
    check("auto_tsv", ra_tsv, TS_W);
    tick();
    check("auto_done", {ra_done, ra_idm, ra_tsm, ra_to}, 4'b1110);

    // restart from DONE, ts word wrong, start during RD_ID ignored
    slv_a_ts = 32'h0000_0000;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("rs_rd_id", {ra_busy, ra_read, ra_addr}, 3'b110);
    check("rs_clear", {ra_done, ra_idm, ra_tsm}, 3'b000);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("ign_rd_ts", {ra_read, ra_addr}, 2'b11);
    tick();
    check("ign_done_st", {ra_busy, ra_read}, 2'b00);
    tick();
    check("ts0_result", {ra_done, ra_idm, ra_tsm}, 3'b110);
    check("ts0_value", ra_tsv, 32'h0000_0000);
    tick(3);
    check("no_queue", {ra_done, ra_busy, ra_read}, 3'b100);

    // single-bit ID difference
    slv_a_ts = TS_W; slv_a_id = ID_W ^ 32'h8000_0000;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(3);
    check("idbit_result", {ra_done, ra_idm, ra_tsm}, 3'b101);
    check("idbit_value", ra_idv, 32'hD24E_FFAE);

    // reset asserted during RD_TS, automatic rerun afterwards
    slv_a_id = ID_W;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    check("mid_rd_ts", {ra_read, ra_addr}, 2'b11);
    reset_a = 1'b1; tick();
    check("mid_rst_out", {ra_read, ra_addr, ra_busy, ra_done, ra_idm, ra_tsm, ra_to}, 0);
    check("mid_rst_idv", ra_idv, 0);
    check("mid_rst_tsv", ra_tsv, 0);
    reset_a = 1'b0; tick();
    check("rerun_rd_id", {ra_busy, ra_read, ra_addr}, 3'b110);
    tick(3);
    check("rerun_done", {ra_done, ra_idm, ra_tsm}, 3'b111);

`ifdef SYSID_CHECK_CTRL_TIMEOUT_EN
    // stuck waitrequest: read drops after 8 stalled cycles
    ra_wait = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(7);
    check("to_still_rd", {ra_read, ra_to}, 2'b10);
    tick();
    check("to_fire", {ra_read, ra_busy, ra_to}, 3'b001);
    tick();
    check("to_done", {ra_done, ra_idm, ra_tsm, ra_to}, 4'b1001);
    ra_wait = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("to_cleared", {ra_to, ra_done}, 2'b00);
    tick(3);
    check("to_recover", {ra_done, ra_idm, ra_tsm, ra_to}, 4'b1110);
`else
    // stuck waitrequest without watchdog: read held indefinitely
    ra_wait = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(12);
    check("stall_hold", {ra_read, ra_addr, ra_busy, ra_to}, 4'b1010);
    ra_wait = 1'b0;
    tick(3);
    check("stall_release", {ra_done, ra_idm, ra_tsm, ra_to}, 4'b1110);
`endif

    // instance B: no auto start, latency 1, four stalled ID cycles
    check("b_idle", {rb_busy, rb_read, rb_done}, 3'b000);
    rb_wait = 1'b1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("b_stall_rd", {rb_read, rb_addr}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_stall_rd", {rb_read, rb_addr}, 2'b10);
    end
    rb_wait = 1'b0;
    tick();
    check("b_lat_id", {rb_busy, rb_read}, 2'b10);
    tick();
    check("b_rd_ts", {rb_read, rb_addr}, 2'b11);
    check("b_idv", rb_idv, ID_W);
    tick();
    check("b_lat_ts", {rb_busy, rb_read}, 2'b10);
    tick();
    check("b_done_st", {rb_busy, rb_done}, 2'b00);
    check("b_tsv", rb_tsv, TS_W);
    tick();
    check("b_done", {rb_done, rb_idm, rb_tsm, rb_to}, 4'b1110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
